// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit. HI/LO and done arrive WIDTH+1 cycles after the start edge.
// Only one operation runs at a time, and start is ignored while busy is high.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_main;
  logic               neg_rem;
  logic               dbz_pend;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  logic               op_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_neg;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_signed = ~md_op[0];
  assign a_neg     = op_signed & A[WIDTH-1];
  assign b_neg     = op_signed & B[WIDTH-1];
  assign a_mag     = a_neg ? -A : A;
  assign b_mag     = b_neg ? -B : B;

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  // Divide: acc holds {partial remainder, remaining dividend / growing quotient}.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_sub   = div_shift[WIDTH-1:0] - opnd;

  assign acc_neg   = -acc;
  assign quo_fix   = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  // With a zero divisor every step subtracts nothing, so the remainder ends as |A| and its sign fix restores A.
  assign rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_main    <= 1'b0;
      neg_rem     <= 1'b0;
      dbz_pend    <= 1'b0;
      opnd        <= '0;
      acc         <= '0;
      hi_out      <= '0;
      lo_out      <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= '0;
            is_div   <= md_op[1];
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            dbz_pend <= md_op[1] && (B == '0);
            opnd     <= md_op[1] ? b_mag : a_mag;
            acc      <= md_op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div)
            acc <= {(div_ge ? div_sub : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
          else
            acc <= {mul_sum, acc[WIDTH-1:1]};
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= dbz_pend;
          if (is_div) begin
            hi_out <= rem_fix;
            lo_out <= dbz_pend ? '1 : quo_fix;
          end else begin
            hi_out <= neg_main ? acc_neg[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            lo_out <= neg_main ? acc_neg[WIDTH-1:0] : acc[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus random ops against a plain-arithmetic model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  md_op;
  logic [31:0] A, B, hi_out, lo_out;
  logic        busy, done, div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .md_op(md_op), .A(A), .B(B),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {div_by_zero, HI, LO}.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      2'b00: begin up = 64'(sa * sb); return {1'b0, up}; end
      2'b01: begin up = ua * ub;      return {1'b0, up}; end
      default: begin
        if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
          sq = sa / sb;
          sr = sa % sb;
          return {1'b0, sr[31:0], sq[31:0]};
        end
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op and checks latency, busy, results; when chained the next op starts in this op's done cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit chained);
    logic [64:0] e;
    int cyc, busy_drop;
    e = model(op, a, b);
    @(negedge clk);
    start = 1'b1; md_op = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = 2'($urandom); A = $urandom; B = $urandom;
    chk({tag, " busy_after_start"}, 64'(busy), 64'd1);
    cyc = 0;
    busy_drop = 0;
    while (!done && cyc < 100) begin
      if (!busy) busy_drop++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'd33);
    chk({tag, " busy_hold"}, 64'(busy_drop), 64'd0);
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, " hi"}, 64'(hi_out), 64'(e[63:32]));
    chk({tag, " lo"}, 64'(lo_out), 64'(e[31:0]));
    chk({tag, " dbz"}, 64'(div_by_zero), 64'(e[64]));
    if (!chained) begin
      @(posedge clk); #1;
      chk({tag, " done_pulse"}, 64'(done), 64'd0);
      chk({tag, " dbz_hold"}, 64'(div_by_zero), 64'(e[64]));
      chk({tag, " lo_hold"}, 64'(lo_out), 64'(e[31:0]));
    end
  endtask

  initial begin
    int cyc, n_done;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; md_op = 2'b00; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst hi", 64'(hi_out), 64'd0);
    chk("rst lo", 64'(lo_out), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_max hi_const", 64'(hi_out), 64'hFFFF_FFFE);
    chk("multu_max lo_const", 64'(lo_out), 64'h1);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    chk("mult_neg lo_const", 64'(lo_out), 64'hFFFF_FFEB);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_neg lo_const", 64'(lo_out), 64'hFFFF_FFFD);
    chk("div_neg hi_const", 64'(hi_out), 64'hFFFF_FFFF);
    run_op("divu", 2'b11, 32'd100, 32'd7, 1'b0);
    chk("divu lo_const", 64'(lo_out), 64'd14);
    chk("divu hi_const", 64'(hi_out), 64'd2);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf lo_const", 64'(lo_out), 64'h8000_0000);
    chk("div_ovf hi_const", 64'(hi_out), 64'h0);
    run_op("divu_zero", 2'b11, 32'd5, 32'd0, 1'b0);
    chk("divu_zero dbz_const", 64'(div_by_zero), 64'd1);
    run_op("multu_clr", 2'b01, 32'd2, 32'd3, 1'b0);
    chk("multu_clr lo_const", 64'(lo_out), 64'd6);
    chk("multu_clr dbz_const", 64'(div_by_zero), 64'd0);
    run_op("div_zero_neg", 2'b10, 32'h8000_0007, 32'd0, 1'b0);

    // A second start pulse while busy must not disturb the running multiply.
    @(negedge clk);
    start = 1'b1; md_op = 2'b01; A = 32'd3; B = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; md_op = 2'b11; A = 32'd9; B = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 10;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ignore latency", 64'(cyc), 64'd33);
    chk("ignore hi", 64'(hi_out), 64'd0);
    chk("ignore lo", 64'(lo_out), 64'd12);
    @(posedge clk); #1;
    chk("ignore no_second_op", 64'(busy), 64'd0);

    run_op("b2b_first", 2'b01, 32'd1234, 32'd5678, 1'b1);
    run_op("b2b_second", 2'b11, 32'd1000, 32'd9, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = pick_operand();
      rb  = pick_operand();
      run_op($sformatf("rnd%0d", i), rop, ra, rb, ($urandom_range(0, 3) == 0));
    end

    run_op("pre_reset", 2'b01, 32'h1234, 32'h5678, 1'b0);
    @(negedge clk);
    start = 1'b1; md_op = 2'b11; A = 32'd1000; B = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort hi", 64'(hi_out), 64'd0);
    chk("abort lo", 64'(lo_out), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    rst = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("abort no_done", 64'(n_done), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
